dmem_arbiter: RTL and testbench

Shares the single data-memory port (the `dataMem` interface: `addr`, `val_write`, `wrEn`, `reEn`, `val_read`) between two requesters. Port 0 is the memory-write stage; port 1 is the program/data loader used at boot and for debug. Each access is sequenced over a fixed multi-cycle memory latency, with a req/ack handshake per port. Out-of-range accesses are rejected before they reach memory, and the block keeps a sticky `memerror` flag for the processor status logic.

---
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: shares one data-memory port between the memory-write stage (p0) and the loader (p1).
// Latency: a legal access acks LATENCY cycles after its grant edge; a rejected one acks right after the grant edge.
// Backpressure: each req is held until its one-cycle ack; a held req is re-granted only after RESP, ties alternate.
module dmem_arbiter #(
   parameter int LATENCY   = 2,
   parameter int MEM_BYTES = 8192
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [63:0] p0_addr,
   input  logic [63:0] p0_wdata,
   output logic        p0_ack,
   output logic [63:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [63:0] p1_addr,
   input  logic [63:0] p1_wdata,
   output logic        p1_ack,
   output logic [63:0] p1_rdata,
   output logic        p1_err,
   output logic [63:0] addr,
   output logic [63:0] val_write,
   output logic        wrEn,
   output logic        reEn,
   input  logic [63:0] val_read,
   output logic        memerror
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Counter is wide enough to hold LATENCY itself.
   localparam int           CW       = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   // Highest legal byte address: a full 8-byte word must fit in memory.
   localparam logic [63:0]  ADDR_MAX = 64'(MEM_BYTES - 8);

   state_t         state_q, state_d;
   logic           last_q;          // port granted most recently (1 after reset so p0 wins the first tie)
   logic [CW-1:0]  cnt_q;
   logic           sel_q;           // port owning the current transaction
   logic           wr_q;
   logic [63:0]    addr_q;
   logic [63:0]    wdata_q;
   logic           err_q;           // current transaction was rejected by the range check
   logic           memerror_q;
   logic [63:0]    rdata0_q;
   logic [63:0]    rdata1_q;

   logic           req_any;
   logic           pick;
   logic           pick_wr;
   logic [63:0]    pick_addr;
   logic [63:0]    pick_wdata;
   logic           pick_bad;
   logic           load;
   logic           capture;
   logic           in_resp;

   // Winner selection: a lone requester wins, a tie goes to the port not granted last time.
   always_comb begin
      req_any    = p0_req | p1_req;
      pick       = (p0_req & p1_req) ? ~last_q : p1_req;
      pick_wr    = pick ? p1_wr    : p0_wr;
      pick_addr  = pick ? p1_addr  : p0_addr;
      pick_wdata = pick ? p1_wdata : p0_wdata;
      pick_bad   = (pick_addr > ADDR_MAX);
   end

   // Next-state logic: grant from IDLE, count down the access, single RESP cycle back to IDLE.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      capture = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_any) begin
               load    = 1'b1;
               state_d = pick_bad ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == CNT_ONE) begin
               capture = ~wr_q;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register, tie-break history and access counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            last_q <= pick;
            cnt_q  <= CNT_LOAD;
         end else if (state_q == ACCESS) begin
            cnt_q  <= cnt_q - CNT_ONE;
         end
      end
   end

   // Latch the winner's request so the other port's inputs are ignored for the whole transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (load) begin
         sel_q   <= pick;
         wr_q    <= pick_wr;
         addr_q  <= pick_addr;
         wdata_q <= pick_wdata;
         err_q   <= pick_bad;
      end
   end

   // Read data is captured on the final ACCESS cycle into the owner's register only; writes and rejects leave it alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (capture) begin
         if (sel_q) begin
            rdata1_q <= val_read;
         end else begin
            rdata0_q <= val_read;
         end
      end
   end

   // Sticky error flag; only reset clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         memerror_q <= 1'b0;
      end else if (in_resp && err_q) begin
         memerror_q <= 1'b1;
      end
   end

   // Outputs decode straight from state so reset removes strobes and acks immediately.
   always_comb begin
      in_resp   = (state_q == RESP);
      wrEn      = (state_q == ACCESS) &  wr_q;
      reEn      = (state_q == ACCESS) & ~wr_q;
      addr      = (state_q == ACCESS) ? addr_q  : '0;
      val_write = (state_q == ACCESS) ? wdata_q : '0;
      p0_ack    = in_resp & ~sel_q;
      p1_ack    = in_resp &  sel_q;
      p0_err    = p0_ack & err_q;
      p1_err    = p1_ack & err_q;
      p0_rdata  = rdata0_q;
      p1_rdata  = rdata1_q;
      // The flag is visible in the same cycle as the first err, not one cycle later.
      memerror  = memerror_q | (in_resp & err_q);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter with a word memory responder and an ack-driven scoreboard.
// Latency: main instance LATENCY=2; two side instances (LATENCY=1 and 5) measure grant-to-ack and spacing.
// Backpressure: requesters hold req until ack and drop it in the ack cycle unless a repeat is intended.
module tb_dmem_arbiter;

   localparam int L_MAIN = 2;

   typedef struct {
      logic        port;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        exp_err;
      logic [63:0] exp_rdata;   // requesting port's rdata after the ack
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_wr, p1_req, p1_wr;
   logic [63:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [63:0] p0_rdata, p1_rdata;
   logic [63:0] addr, val_write, val_read;
   logic        wrEn, reEn, memerror;

   // Side instances for the latency sweep: index 0 is LATENCY=1, index 1 is LATENCY=5.
   logic        s_req   [2];
   logic        s_ack0  [2];
   logic        s_err0  [2];
   logic [63:0] s_rd0   [2];
   logic        s_ack1  [2];
   logic        s_err1  [2];
   logic [63:0] s_rd1   [2];
   logic [63:0] s_addr_o[2];
   logic [63:0] s_vw    [2];
   logic        s_we    [2];
   logic        s_re    [2];
   logic        s_me    [2];
   logic        z1;
   logic [63:0] z64;
   logic [63:0] s_addr;
   logic [63:0] s_vr;

   int          n_assert = 0;
   int          n_fail   = 0;

   vec_t        sb0[$];
   vec_t        sb1[$];
   int          ord_q[$];

   logic [63:0] mem [0:1023];

   dmem_arbiter #(.LATENCY(L_MAIN), .MEM_BYTES(8192)) u_dut (
      .clk(clk), .reset(rst_n),
      .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .addr(addr), .val_write(val_write), .wrEn(wrEn), .reEn(reEn),
      .val_read(val_read), .memerror(memerror)
   );

   dmem_arbiter #(.LATENCY(1), .MEM_BYTES(8192)) u_lat1 (
      .clk(clk), .reset(rst_n),
      .p0_req(s_req[0]), .p0_wr(z1), .p0_addr(s_addr), .p0_wdata(z64),
      .p0_ack(s_ack0[0]), .p0_rdata(s_rd0[0]), .p0_err(s_err0[0]),
      .p1_req(z1), .p1_wr(z1), .p1_addr(z64), .p1_wdata(z64),
      .p1_ack(s_ack1[0]), .p1_rdata(s_rd1[0]), .p1_err(s_err1[0]),
      .addr(s_addr_o[0]), .val_write(s_vw[0]), .wrEn(s_we[0]), .reEn(s_re[0]),
      .val_read(s_vr), .memerror(s_me[0])
   );

   dmem_arbiter #(.LATENCY(5), .MEM_BYTES(8192)) u_lat5 (
      .clk(clk), .reset(rst_n),
      .p0_req(s_req[1]), .p0_wr(z1), .p0_addr(s_addr), .p0_wdata(z64),
      .p0_ack(s_ack0[1]), .p0_rdata(s_rd0[1]), .p0_err(s_err0[1]),
      .p1_req(z1), .p1_wr(z1), .p1_addr(z64), .p1_wdata(z64),
      .p1_ack(s_ack1[1]), .p1_rdata(s_rd1[1]), .p1_err(s_err1[1]),
      .addr(s_addr_o[1]), .val_write(s_vw[1]), .wrEn(s_we[1]), .reEn(s_re[1]),
      .val_read(s_vr), .memerror(s_me[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] dv(input int i);
      return 64'hC0DE_0000_0000_0000 + 64'(i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Word-addressed memory responder; reads are combinational, writes land on the strobed edge.
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = dv(i);
   end
   assign val_read = mem[addr[12:3]];
   always @(posedge clk) begin
      if (wrEn) mem[addr[12:3]] <= val_write;
   end

   // Scoreboard monitor: tracks strobes per transaction and checks every ack against the queued expectation.
   int          st_cnt;
   logic [63:0] st_addr, st_wdata;
   logic        st_wr;
   logic        prev0, prev1;
   int          ack_port, exp_port;
   vec_t        e;
   always @(negedge clk) begin
      if (!rst_n) begin
         st_cnt = 0;
         prev0  = 1'b0;
         prev1  = 1'b0;
      end else begin
         check("strobe_exclusive", {63'd0, wrEn & reEn}, 64'd0);
         if (wrEn | reEn) begin
            st_cnt++;
            st_addr  = addr;
            st_wdata = val_write;
            st_wr    = wrEn;
         end
         if (p0_ack | p1_ack) begin
            check("ack_exclusive", {63'd0, p0_ack & p1_ack}, 64'd0);
            ack_port = p1_ack ? 1 : 0;
            check("ack_one_cycle", {63'd0, (ack_port == 1) ? prev1 : prev0}, 64'd0);
            if (ord_q.size() == 0 || ((ack_port == 1) ? sb1.size() : sb0.size()) == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL unexpected_ack: port %0d acked with nothing outstanding (t=%0t)", ack_port, $time);
            end else begin
               exp_port = ord_q.pop_front();
               check("grant_order", 64'(ack_port), 64'(exp_port));
               e = (ack_port == 1) ? sb1.pop_front() : sb0.pop_front();
               check("ack_err", {63'd0, (ack_port == 1) ? p1_err : p0_err}, {63'd0, e.exp_err});
               if (e.exp_err) check("memerror_with_err", {63'd0, memerror}, 64'd1);
               check("ack_rdata", (ack_port == 1) ? p1_rdata : p0_rdata, e.exp_rdata);
               check("strobe_cycles", 64'(st_cnt), e.exp_err ? 64'd0 : 64'(L_MAIN));
               if (!e.exp_err) begin
                  check("strobe_addr", st_addr, e.addr);
                  check("strobe_kind", {63'd0, st_wr}, {63'd0, e.wr});
                  if (e.wr) check("strobe_wdata", st_wdata, e.wdata);
               end
            end
            st_cnt = 0;
         end
         prev0 = p0_ack;
         prev1 = p1_ack;
      end
   end

   // One single-port transaction: queue the expectation, raise req, wait (bounded) for ack, drop req.
   task automatic do_txn(input vec_t v);
      logic got;
      @(negedge clk);
      if (v.port) sb1.push_back(v); else sb0.push_back(v);
      ord_q.push_back(v.port ? 1 : 0);
      if (v.port) begin
         p1_wr = v.wr; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1'b1;
      end else begin
         p0_wr = v.wr; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1'b1;
      end
      got = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (v.port ? p1_ack : p0_ack) begin
            got = 1'b1;
            break;
         end
      end
      p0_req = 1'b0;
      p1_req = 1'b0;
      check("txn_ack_seen", {63'd0, got}, 64'd1);
   endtask

   // Grant-to-ack latency and back-to-back spacing on one side instance.
   task automatic sweep(input int k, input int lat);
      int n;
      int m;
      @(negedge clk);
      s_req[k] = 1'b1;
      @(posedge clk);
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (s_ack0[k]) break;
         @(posedge clk);
         n++;
      end
      check("sweep_latency", 64'(n), 64'(lat));
      check("sweep_rdata", s_rd0[k], 64'h0123_4567_89AB_CDEF);
      m = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         m++;
         @(negedge clk);
         if (s_ack0[k]) break;
      end
      check("sweep_spacing", 64'(m), 64'(lat + 2));
      s_req[k] = 1'b0;
      repeat (lat + 3) @(negedge clk);
      check("sweep_quiet", {63'd0, s_ack0[k]}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   vec_t        tab[12];
   logic [63:0] exp_rd[2];
   logic        exp_me;
   int          n0, n1;
   vec_t        tmp;

   initial begin
      // Directed table: {port, wr, addr, wdata, exp_err, exp_rdata of that port afterwards}.
      // Before the table, p0_rdata=dv(4) and p1_rdata=dv(5) from the tie test.
      tab[0]  = '{1'b0, 1'b1, 64'd1000, 64'd80,         1'b0, dv(4)};
      tab[1]  = '{1'b0, 1'b0, 64'd1000, 64'd0,          1'b0, 64'd80};
      tab[2]  = '{1'b1, 1'b0, 64'd8190, 64'd0,          1'b1, dv(5)};
      tab[3]  = '{1'b1, 1'b1, 64'd8184, 64'hDEAD_BEEF,  1'b0, dv(5)};
      tab[4]  = '{1'b1, 1'b0, 64'd8184, 64'd0,          1'b0, 64'hDEAD_BEEF};
      tab[5]  = '{1'b0, 1'b0, 64'd8185, 64'd0,          1'b1, 64'd80};
      tab[6]  = '{1'b0, 1'b1, 64'd8,    64'h1234,       1'b0, 64'd80};
      tab[7]  = '{1'b1, 1'b0, 64'd8,    64'd0,          1'b0, 64'h1234};
      tab[8]  = '{1'b0, 1'b0, 64'd0,    64'd0,          1'b0, dv(0)};
      tab[9]  = '{1'b1, 1'b1, 64'd8192, 64'h5555,       1'b1, 64'h1234};
      tab[10] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h9, 1'b1, dv(0)};
      tab[11] = '{1'b1, 1'b0, 64'd1000, 64'd0,          1'b0, 64'd80};

      z1 = 1'b0; z64 = '0; s_addr = 64'h40; s_vr = 64'h0123_4567_89AB_CDEF;
      s_req[0] = 1'b0; s_req[1] = 1'b0;

      // Reset with random inputs: every output must read zero.
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         p0_req = 1'($urandom); p0_wr = 1'($urandom); p0_addr = {$urandom, $urandom}; p0_wdata = {$urandom, $urandom};
         p1_req = 1'($urandom); p1_wr = 1'($urandom); p1_addr = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
      end
      @(negedge clk);
      check("rst_acks",    {62'd0, p0_ack, p1_ack}, 64'd0);
      check("rst_errs",    {62'd0, p0_err, p1_err}, 64'd0);
      check("rst_strobes", {62'd0, wrEn, reEn}, 64'd0);
      check("rst_addr", addr, 64'd0);
      check("rst_val_write", val_write, 64'd0);
      check("rst_p0_rdata", p0_rdata, 64'd0);
      check("rst_p1_rdata", p1_rdata, 64'd0);
      check("rst_memerror", {63'd0, memerror}, 64'd0);
      p0_req = 1'b0; p1_req = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", {60'd0, wrEn, reEn, p0_ack, p1_ack}, 64'd0);

      // Tie from reset, both held: p0, p1, p0, p1.
      p0_wr = 1'b0; p0_addr = 64'd32; p1_wr = 1'b0; p1_addr = 64'd40;
      tmp = '{1'b0, 1'b0, 64'd32, 64'd0, 1'b0, dv(4)};
      sb0.push_back(tmp); sb0.push_back(tmp);
      tmp = '{1'b1, 1'b0, 64'd40, 64'd0, 1'b0, dv(5)};
      sb1.push_back(tmp); sb1.push_back(tmp);
      ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
      p0_req = 1'b1; p1_req = 1'b1;
      n0 = 0; n1 = 0;
      for (int c = 0; c < 60 && (n0 < 2 || n1 < 2); c++) begin
         @(negedge clk);
         if (p0_ack) begin n0++; if (n0 == 2) p0_req = 1'b0; end
         if (p1_ack) begin n1++; if (n1 == 2) p1_req = 1'b0; end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      check("tie_p0_count", 64'(n0), 64'd2);
      check("tie_p1_count", 64'(n1), 64'd2);

      // Table-driven single-port accesses, checking held rdata and sticky memerror after each.
      exp_rd[0] = dv(4); exp_rd[1] = dv(5); exp_me = 1'b0;
      for (int i = 0; i < 12; i++) begin
         do_txn(tab[i]);
         exp_rd[tab[i].port ? 1 : 0] = tab[i].exp_rdata;
         exp_me = exp_me | tab[i].exp_err;
         check("tab_p0_rdata", p0_rdata, exp_rd[0]);
         check("tab_p1_rdata", p1_rdata, exp_rd[1]);
         check("tab_memerror", {63'd0, memerror}, {63'd0, exp_me});
      end

      // Reset during the first wrEn cycle of a p0 write; the held req is re-granted afterwards.
      @(negedge clk);
      p0_wr = 1'b1; p0_addr = 64'd24; p0_wdata = 64'h77; p0_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_wren_before", {63'd0, wrEn}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_strobes", {62'd0, wrEn, reEn}, 64'd0);
      check("midrst_addr", addr, 64'd0);
      check("midrst_memerror", {63'd0, memerror}, 64'd0);
      check("midrst_p0_rdata", p0_rdata, 64'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("midrst_no_ack", {63'd0, p0_ack}, 64'd0);
      end
      tmp = '{1'b0, 1'b1, 64'd24, 64'h77, 1'b0, 64'd0};
      sb0.push_back(tmp);
      ord_q.push_back(0);
      rst_n = 1'b1;
      n0 = 0;
      for (int c = 0; c < 30 && n0 == 0; c++) begin
         @(negedge clk);
         if (p0_ack) n0++;
      end
      p0_req = 1'b0;
      check("midrst_regrant_ack", 64'(n0), 64'd1);
      tmp = '{1'b1, 1'b0, 64'd24, 64'd0, 1'b0, 64'h77};
      do_txn(tmp);
      check("midrst_readback", p1_rdata, 64'h77);

      // Latency sweep on the side instances.
      sweep(0, 1);
      sweep(1, 5);

      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb0.size() + sb1.size() + ord_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
